mul_fitness_eval: RTL
=====================

Name: mul_fitness_eval

Overview:
- Sequential fitness evaluator for the evolved combinational 32x32 limb multipliers in this flow.
- A candidate takes operand limbs a1,a0,b1,b0 (16 bits each) and returns product limbs y3..y0 (16 bits each).
- This block sits around the candidate. It generates pseudo-random operand pairs, drives them into the candidate, and samples the candidate's outputs.
- It compares each sample against an internal golden 64-bit product and accumulates an exact-match count and a correct-bit score for the GE fitness function.

Parameters:
- N_VECTORS, 256, number of operand pairs per evaluation run (1..65535).
- SETTLE_CYCLES, 1, cycles between driving a vector and sampling the candidate (>=1).
- SCORE_W, $clog2(N_VECTORS*64+1), width of bit_score.
- CNT_W, $clog2(N_VECTORS+1), width of match_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- seed  in  32  LFSR seed; captured on accepted start.
- busy  out  1  high from start acceptance until result_valid rises.
- cand_a1, cand_a0, cand_b1, cand_b0  out  16 each  registered operand limbs to the candidate.
- cand_y3, cand_y2, cand_y1, cand_y0  in  16 each  candidate product limbs (combinational from cand_*).
- result_valid  out  1  run finished; scores are valid.
- result_ready  in  1  consumer accepts the result.
- match_count  out  CNT_W  number of vectors where {y3,y2,y1,y0} equals the golden product exactly.
- bit_score  out  SCORE_W  total number of product bits matching golden, summed over all vectors.

Behaviour:
- Reset (async, immediate): state=IDLE; busy=0; result_valid=0; cand_*=0; match_count=0; bit_score=0; LFSR=1; vector and settle counters=0.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
- IDLE: if start=1 at an edge:
  - capture seed; seed==0 is replaced by 32'h1;
  - clear both scores; set busy=1; go to DRIVE.
- DRIVE (1 cycle):
  - A = current LFSR state; LFSR advances one step; B = the advanced state; LFSR advances again.
  - Register cand_{a1,a0}=A and cand_{b1,b0}=B.
  - Register golden = A*B, unsigned 64-bit.
  - Go to SETTLE with settle counter = SETTLE_CYCLES-1.
- SETTLE: decrement the counter each cycle; when it reaches 0, go to SAMPLE. With SETTLE_CYCLES=1 this state lasts exactly 1 cycle.
- SAMPLE (1 cycle):
  - match_count += (cand_y == golden).
  - bit_score += popcount(~(cand_y ^ golden)), with cand_y = {y3,y2,y1,y0}.
  - Increment the vector counter. If it now equals N_VECTORS, go to DONE; otherwise go to DRIVE.
- Per-vector cost is SETTLE_CYCLES+2 cycles. result_valid rises exactly N_VECTORS*(SETTLE_CYCLES+2) cycles after the edge that accepted start.
- DONE:
  - result_valid=1; busy=0; scores held stable.
  - On result_valid&&result_ready: result_valid clears and the FSM returns to IDLE. Scores keep their values until the next accepted start.
- start is ignored in every state except IDLE, including the accept cycle of DONE.
- LFSR: 32-bit Galois, taps mask 32'h80200003, shifts right, XORs the mask when the LSB is 1. It never reaches 0 from a nonzero seed, so operands are never zero.
- cand_* change only in DRIVE. They are held through SETTLE/SAMPLE and hold the last vector in DONE and IDLE.
- Arithmetic: both accumulators are sized by the parameters to never overflow. No saturation logic.
- Reset asserted mid-run aborts the run immediately. No partial result is presented.

Optional Feature:
- Macro: MUL_FITNESS_CORNER_EN.
- Defined: the first 4 vectors of each run are fixed corner pairs, in this order:
  1. (FFFFFFFF, FFFFFFFF)
  2. (FFFFFFFF, 00000001)
  3. (0000FFFF, FFFF0000)
  4. (80000000, 80000000)
- The LFSR does not advance during corner vectors and supplies vectors 5..N_VECTORS. Requires N_VECTORS>=4.
- Not defined: all vectors come from the LFSR.

Decomposition:
- Package mul_fitness_pkg holds:
  - LIMB_W=16;
  - LFSR_TAPS=32'h80200003;
  - state enum eval_state_t;
  - the corner vector constant array;
  - a popcount64 function.
- One sub-module: lfsr32_step, a combinational next-state function, instantiated twice for the A and B draws.

Test Plan:
- Exact-multiplier stub candidate, seed=1, N_VECTORS=256 -> match_count=256, bit_score=16384; result_valid exactly 768 cycles after start.
- All-zero candidate outputs -> match_count=0; bit_score equals the bench-model count of zero bits in the golden products.
- Stub with y3 inverted -> match_count=0, bit_score=12288.
- seed=0 vs seed=1, same stub -> identical scores and identical cand_* sequence.
- result_ready held low 50 cycles, start pulsed in DONE -> result_valid and scores stable; no new run; one-cycle ready returns to IDLE.
- rst pulsed mid-run at vector 100 -> all outputs at reset values immediately; a new start yields the full clean result.

Source files
------------

// File: rtl/mul_fitness_eval_pkg.sv
// -----------------------------------------------------------------------------
// mul_fitness_pkg
// Shared definitions for the multiplier fitness evaluator:
//   LIMB_W       width of one operand/product limb
//   LFSR_TAPS    Galois feedback mask for the 32-bit operand generator
//   eval_state_t evaluator FSM states
//   CORNER_VECS  fixed corner operand pairs {A,B}, index 0 is driven first
//                (used only when MUL_FITNESS_CORNER_EN is defined)
//   popcount64   number of set bits in a 64-bit word
// -----------------------------------------------------------------------------
package mul_fitness_pkg;

   localparam int          LIMB_W    = 16;
   localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRIVE,
      S_SETTLE,
      S_SAMPLE,
      S_DONE
   } eval_state_t;

   // Packed concatenation lists the highest index first, so element 0 is the
   // last entry below: the all-ones square is the first corner driven.
   localparam logic [3:0][63:0] CORNER_VECS = {
      64'h8000_0000_8000_0000,
      64'h0000_FFFF_FFFF_0000,
      64'hFFFF_FFFF_0000_0001,
      64'hFFFF_FFFF_FFFF_FFFF
   };

   function automatic logic [6:0] popcount64(input logic [63:0] v);
      logic [6:0] cnt;
      cnt = '0;
      for (int i = 0; i < 64; i++) begin
         cnt = cnt + {6'd0, v[i]};
      end
      return cnt;
   endfunction

endpackage

// File: rtl/mul_fitness_eval_lfsr32_step.sv
// -----------------------------------------------------------------------------
// lfsr32_step
// One step of the 32-bit right-shifting Galois LFSR (purely combinational).
// Ports:
//   i_state  [31:0]  current LFSR state
//   o_next   [31:0]  state after one shift (mask XORed when the old LSB is 1)
// -----------------------------------------------------------------------------
module lfsr32_step
   import mul_fitness_pkg::*;
(
   input  logic [31:0] i_state,
   output logic [31:0] o_next
);

   assign o_next = (i_state >> 1) ^ (i_state[0] ? LFSR_TAPS : 32'h0);

endmodule

// File: rtl/mul_fitness_eval.sv
// -----------------------------------------------------------------------------
// mul_fitness_eval
// Sequential fitness evaluator wrapped around a combinational 32x32 limb
// multiplier candidate. Each run drives N_VECTORS pseudo-random operand pairs,
// samples the candidate SETTLE_CYCLES after each drive and accumulates an
// exact-match count and a correct-bit score against a golden 64-bit product.
//
// Optional build macro: MUL_FITNESS_CORNER_EN -- the first 4 vectors of each
// run are the fixed corner pairs from mul_fitness_pkg and the LFSR holds while
// they are driven (needs N_VECTORS >= 4).
//
// Ports:
//   i_clk             clock, rising edge
//   i_rst             asynchronous active-high reset
//   i_start           run request, only looked at in IDLE
//   i_seed[31:0]      LFSR seed captured on an accepted start (0 -> 1)
//   o_busy            high from start acceptance until o_result_valid rises
//   o_cand_a1/a0/b1/b0[15:0]  registered operand limbs to the candidate
//   i_cand_y3..y0[15:0]       candidate product limbs
//   o_result_valid    run finished, scores valid
//   i_result_ready    consumer accepts the result
//   o_match_count     vectors whose product matched the golden exactly
//   o_bit_score       product bits matching the golden, summed over the run
// -----------------------------------------------------------------------------
module mul_fitness_eval
   import mul_fitness_pkg::*;
#(
   parameter int N_VECTORS     = 256,
   parameter int SETTLE_CYCLES = 1,
   parameter int SCORE_W       = $clog2(N_VECTORS * 64 + 1),
   parameter int CNT_W         = $clog2(N_VECTORS + 1)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_start,
   input  logic [31:0]        i_seed,
   output logic               o_busy,
   output logic [LIMB_W-1:0]  o_cand_a1,
   output logic [LIMB_W-1:0]  o_cand_a0,
   output logic [LIMB_W-1:0]  o_cand_b1,
   output logic [LIMB_W-1:0]  o_cand_b0,
   input  logic [LIMB_W-1:0]  i_cand_y3,
   input  logic [LIMB_W-1:0]  i_cand_y2,
   input  logic [LIMB_W-1:0]  i_cand_y1,
   input  logic [LIMB_W-1:0]  i_cand_y0,
   output logic               o_result_valid,
   input  logic               i_result_ready,
   output logic [CNT_W-1:0]   o_match_count,
   output logic [SCORE_W-1:0] o_bit_score
);

   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   eval_state_t        r_state;
   eval_state_t        w_state_next;
   logic [31:0]        r_lfsr;
   logic [31:0]        w_lfsr_b;
   logic [31:0]        w_lfsr_nn;
   logic [31:0]        w_op_a;
   logic [31:0]        w_op_b;
   logic [31:0]        w_lfsr_after;
   logic [CNT_W-1:0]   r_vec_cnt;
   logic [CNT_W-1:0]   w_vec_inc;
   logic [SET_W-1:0]   r_settle_cnt;
   logic [63:0]        r_golden;
   logic [63:0]        w_cand_y;
   logic [CNT_W-1:0]   r_match_count;
   logic [SCORE_W-1:0] r_bit_score;

   // Two chained steps: B is the state after one step, the LFSR lands two
   // steps ahead once a vector has been drawn.
   lfsr32_step u_step_b (
      .i_state (r_lfsr),
      .o_next  (w_lfsr_b)
   );

   lfsr32_step u_step_nn (
      .i_state (w_lfsr_b),
      .o_next  (w_lfsr_nn)
   );

   assign w_cand_y  = {i_cand_y3, i_cand_y2, i_cand_y1, i_cand_y0};
   assign w_vec_inc = r_vec_cnt + CNT_W'(1);

   // Operand source for the vector being drawn in DRIVE.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave it unassigned and infer a latch.
      w_op_a       = r_lfsr;
      w_op_b       = w_lfsr_b;
      w_lfsr_after = w_lfsr_nn;
`ifdef MUL_FITNESS_CORNER_EN
      if (r_vec_cnt < CNT_W'(4)) begin
         w_op_a       = CORNER_VECS[r_vec_cnt[1:0]][63:32];
         w_op_b       = CORNER_VECS[r_vec_cnt[1:0]][31:0];
         w_lfsr_after = r_lfsr;
      end
`endif
   end

   // FSM: state register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // FSM: next state and state-decoded outputs.
   always_comb begin
      w_state_next   = r_state;
      o_busy         = 1'b0;
      o_result_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_state_next = S_DRIVE;
         end
         S_DRIVE: begin
            o_busy       = 1'b1;
            w_state_next = S_SETTLE;
         end
         S_SETTLE: begin
            o_busy = 1'b1;
            if (r_settle_cnt == '0) w_state_next = S_SAMPLE;
         end
         S_SAMPLE: begin
            o_busy = 1'b1;
            if (w_vec_inc == CNT_W'(N_VECTORS)) w_state_next = S_DONE;
            else                                w_state_next = S_DRIVE;
         end
         S_DONE: begin
            o_result_valid = 1'b1;
            if (i_result_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Datapath: operand generation, golden product and score accumulation.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lfsr        <= 32'h1;
         r_vec_cnt     <= '0;
         r_settle_cnt  <= '0;
         r_golden      <= '0;
         o_cand_a1     <= '0;
         o_cand_a0     <= '0;
         o_cand_b1     <= '0;
         o_cand_b0     <= '0;
         r_match_count <= '0;
         r_bit_score   <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  // A zero seed would lock the LFSR at zero forever.
                  r_lfsr        <= (i_seed == 32'h0) ? 32'h1 : i_seed;
                  r_vec_cnt     <= '0;
                  r_match_count <= '0;
                  r_bit_score   <= '0;
               end
            end
            S_DRIVE: begin
               {o_cand_a1, o_cand_a0} <= w_op_a;
               {o_cand_b1, o_cand_b0} <= w_op_b;
               r_golden               <= 64'(w_op_a) * 64'(w_op_b);
               r_lfsr                 <= w_lfsr_after;
               r_settle_cnt           <= SET_W'(SETTLE_CYCLES - 1);
            end
            S_SETTLE: begin
               if (r_settle_cnt != '0) r_settle_cnt <= r_settle_cnt - SET_W'(1);
            end
            S_SAMPLE: begin
               if (w_cand_y == r_golden) r_match_count <= r_match_count + CNT_W'(1);
               r_bit_score <= r_bit_score + SCORE_W'(popcount64(~(w_cand_y ^ r_golden)));
               r_vec_cnt   <= w_vec_inc;
            end
            default: ;
         endcase
      end
   end

   assign o_match_count = r_match_count;
   assign o_bit_score   = r_bit_score;

endmodule
